// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressable little-endian data memory with wait states and fault flagging
module data_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [2:0]          r_func3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_fault;
    logic                r_resp_valid;
    logic                r_err;
    logic [31:0]         r_rdata;

    // Zero at power-up only; never cleared by rst_n.
    logic [7:0]          r_mem [DEPTH] = '{default: 8'h00};

    logic                w_accept;
    logic                w_in_fault;
    logic                w_cur_we;
    logic [2:0]          w_cur_func3;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [31:0]         w_cur_wdata;
    logic                w_cur_fault;
    logic                w_enter_resp;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_idx1;
    logic [ADDR_W-1:0]   w_idx2;
    logic [ADDR_W-1:0]   w_idx3;
    logic [7:0]          w_b0;
    logic [7:0]          w_b1;
    logic [7:0]          w_b2;
    logic [7:0]          w_b3;
    logic [31:0]         w_load;

    function automatic logic f_fault(input logic i_st, input logic [2:0] i_f3, input logic [31:0] i_a);
        logic v_bad;
        case (i_f3)
            F3_B:    v_bad = 1'b0;
            F3_H:    v_bad = i_a[0];
            F3_W:    v_bad = |i_a[1:0];
            F3_BU:   v_bad = i_st;
            F3_HU:   v_bad = i_st | i_a[0];
            default: v_bad = 1'b1;
        endcase
        if ((i_a >> ADDR_W) != 32'd0) begin
            v_bad = 1'b1;
        end
        return v_bad;
    endfunction

    assign w_in_fault = f_fault(we, func3, addr);

    // In IDLE the access being accepted is still on the inputs, so a direct
    // jump to RESP (fault or zero latency) must use them instead of the latches.
    assign w_cur_we    = (r_state == S_IDLE) ? we                 : r_we;
    assign w_cur_func3 = (r_state == S_IDLE) ? func3              : r_func3;
    assign w_cur_addr  = (r_state == S_IDLE) ? addr[ADDR_W-1:0]   : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? wdata              : r_wdata;
    assign w_cur_fault = (r_state == S_IDLE) ? w_in_fault         : r_fault;

    // Non-faulting halfword/word accesses are aligned, so a+1..a+3 are just low-bit patterns.
    assign w_idx1 = {w_cur_addr[ADDR_W-1:1], 1'b1};
    assign w_idx2 = {w_cur_addr[ADDR_W-1:2], 2'b10};
    assign w_idx3 = {w_cur_addr[ADDR_W-1:2], 2'b11};
    assign w_b0   = r_mem[w_cur_addr];
    assign w_b1   = r_mem[w_idx1];
    assign w_b2   = r_mem[w_idx2];
    assign w_b3   = r_mem[w_idx3];

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_commit     = w_enter_resp && rst_n && w_cur_we && !w_cur_fault;

    assign ready      = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign err        = r_err;

    // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = (w_in_fault || LAT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Load data selection and sign/zero extension.
    always_comb begin
        w_load = 32'd0;
        case (w_cur_func3)
            F3_B:    w_load = {{24{w_b0[7]}}, w_b0};
            F3_H:    w_load = {{16{w_b1[7]}}, w_b1, w_b0};
            F3_W:    w_load = {w_b3, w_b2, w_b1, w_b0};
            F3_BU:   w_load = {24'd0, w_b0};
            F3_HU:   w_load = {16'd0, w_b1, w_b0};
            default: w_load = 32'd0;
        endcase
    end

    // State register, request latches and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_func3 <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= we;
                r_func3 <= func3;
                r_addr  <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
                r_fault <= w_in_fault;
                r_cnt   <= LAT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
        end else if (w_enter_resp) begin
            r_resp_valid <= 1'b1;
            r_err        <= w_cur_fault;
            r_rdata      <= (w_cur_fault || w_cur_we) ? 32'd0 : w_load;
        end else begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
        end
    end

    // Store commit, LSB first, on the same edge the response is raised.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_cur_addr] <= w_cur_wdata[7:0];
            if (w_cur_func3[1:0] != 2'd0) begin
                r_mem[w_idx1] <= w_cur_wdata[15:8];
            end
            if (w_cur_func3[1:0] == 2'd2) begin
                r_mem[w_idx2] <= w_cur_wdata[23:16];
                r_mem[w_idx3] <= w_cur_wdata[31:24];
            end
        end
    end
endmodule
